mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arbiter_rr_pick.sv | 26 ++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared io definitions for the two-requester memory arbiter
//
// Holds the bus geometry, the RAM width codes, the arbiter state encoding and
// the requester indices used by the arbiter RTL and its bench.

package mem_arbiter_pkg;

  localparam int N_REQ   = 2;
  localparam int ADDR_W  = 28;
  localparam int DATA_W  = 64;
  localparam int WIDTH_W = 2;

  // RAM access width codes, passed through to the DDR2 wrapper untouched.
  typedef enum logic [WIDTH_W-1:0] {
    WIDTH_8  = 2'd0,
    WIDTH_16 = 2'd1,
    WIDTH_32 = 2'd2,
    WIDTH_64 = 2'd3
  } ram_width_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Requester indices.
  localparam logic REQ_CPU   = 1'b0;
  localparam logic REQ_CACHE = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - memory-side bus between the arbiter and the DDR2 wrapper
//
// Signals:
//   mem_addr, mem_width, mem_d_to_ram   command fields (arbiter -> memory)
//   mem_rstrobe, mem_wstrobe            one-cycle read/write launch strobes
//   mem_d_from_ram                      read data (memory -> arbiter)
//   mem_ready                           memory can accept a strobe
//   mem_transaction_complete            memory finished the launched access
// Modports: master = arbiter side, slave = memory wrapper side.

interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic [ADDR_W-1:0]  mem_addr;
  logic [WIDTH_W-1:0] mem_width;
  logic [DATA_W-1:0]  mem_d_to_ram;
  logic               mem_rstrobe;
  logic               mem_wstrobe;
  logic [DATA_W-1:0]  mem_d_from_ram;
  logic               mem_ready;
  logic               mem_transaction_complete;

  modport master (
    output mem_addr, mem_width, mem_d_to_ram, mem_rstrobe, mem_wstrobe,
    input  mem_d_from_ram, mem_ready, mem_transaction_complete
  );

  modport slave (
    input  mem_addr, mem_width, mem_d_to_ram, mem_rstrobe, mem_wstrobe,
    output mem_d_from_ram, mem_ready, mem_transaction_complete
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - combinational 2-way round-robin selector
//
// Ports:
//   req    in  2  level requests
//   last   in  1  index granted most recently
//   valid  out 1  at least one request present
//   idx    out 1  index of the winner (meaningful only with valid)

module rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       idx
);

  assign valid = |req;

  // A lone request wins outright; on a tie the one not granted last wins.
  always_comb begin
    idx = req[1];
    if (&req) begin
      idx = ~last;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter between CPU and cache onto one DDR2 wrapper
//
// Parameters:
//   TIMEOUT_CYCLES  maximum WAIT cycles before a transaction is aborted
// Ports:
//   clk_cpu, rst_n           clock, asynchronous active-low reset
//   req, req_we              per-requester level request and write flag
//   req_addr                 28-bit address per requester, requester i at [28i+27:28i]
//   req_width                2-bit width code per requester
//   req_wdata                64-bit write data per requester
//   done, err                one-cycle completion pulse / timeout flag per requester
//   rdata                    read data, valid with done
//   busy, owner              not idle / index of the current grant
//   mem                      memory bus (master side)

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk_cpu,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*WIDTH_W-1:0]  req_width,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          done,
  output logic [N_REQ-1:0]          err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      owner,
  mem_arbiter_if.master             mem
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t         state;
  logic               last;
  logic               we_q;
  logic [CNT_W-1:0]   cnt;

  logic               pick_valid;
  logic               pick_idx;
  logic               win_we;
  logic [ADDR_W-1:0]  win_addr;
  logic [WIDTH_W-1:0] win_width;
  logic [DATA_W-1:0]  win_wdata;

  rr_pick u_rr_pick (
    .req   (req),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign win_we    = req_we[pick_idx];
  assign win_addr  = pick_idx ? req_addr[2*ADDR_W-1:ADDR_W]     : req_addr[ADDR_W-1:0];
  assign win_width = pick_idx ? req_width[2*WIDTH_W-1:WIDTH_W]  : req_width[WIDTH_W-1:0];
  assign win_wdata = pick_idx ? req_wdata[2*DATA_W-1:DATA_W]    : req_wdata[DATA_W-1:0];

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      done             <= '0;
      err              <= '0;
      rdata            <= '0;
      mem.mem_rstrobe  <= 1'b0;
      mem.mem_wstrobe  <= 1'b0;
      mem.mem_addr     <= '0;
      mem.mem_d_to_ram <= '0;
      mem.mem_width    <= WIDTH_8;
      owner            <= REQ_CPU;
      last             <= REQ_CACHE;
      we_q             <= 1'b0;
      cnt              <= '0;
    end else begin
      // Strobes and done are single-cycle pulses unless set below.
      mem.mem_rstrobe <= 1'b0;
      mem.mem_wstrobe <= 1'b0;
      done            <= '0;

      case (state)
        ST_IDLE: begin
          err <= '0;
          if (pick_valid) begin
            owner            <= pick_idx;
            we_q             <= win_we;
            mem.mem_addr     <= win_addr;
            mem.mem_width    <= win_width;
            mem.mem_d_to_ram <= win_wdata;
            state            <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (mem.mem_ready) begin
            if (we_q) begin
              mem.mem_wstrobe <= 1'b1;
            end else begin
              mem.mem_rstrobe <= 1'b1;
            end
            cnt   <= '0;
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          // done is raised on entry to RESP so it is high for the RESP cycle.
          if (mem.mem_transaction_complete) begin
            if (!we_q) begin
              rdata <= mem.mem_d_from_ram;
            end
            done[owner] <= 1'b1;
            state       <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            err[owner]  <= 1'b1;
            done[owner] <= 1'b1;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RESP: begin
          last  <= owner;
          err   <= '0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter

module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int TMO = 16;

  logic         clk_cpu;
  logic         rst_n;
  logic [1:0]   req;
  logic [1:0]   req_we;
  logic [55:0]  req_addr;
  logic [3:0]   req_width;
  logic [127:0] req_wdata;
  logic [1:0]   done;
  logic [1:0]   err;
  logic [63:0]  rdata;
  logic         busy;
  logic         owner;

  mem_arbiter_if mem_bus ();

  mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_cpu   (clk_cpu),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_width (req_width),
    .req_wdata (req_wdata),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .owner     (owner),
    .mem       (mem_bus.master)
  );

  initial clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  typedef struct {
    logic        idx;
    logic        we;
    logic [27:0] addr;
    logic [1:0]  width;
    logic [63:0] wdata;
    int          rdly;       // cycles mem_ready is held low in ISSUE
    int          cdly;       // WAIT cycles before complete, -1 = never
    logic [63:0] model;      // data the memory presents
    logic        exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic idx, input logic we, input logic [27:0] addr,
                              input logic [1:0] width, input logic [63:0] wdata,
                              input int rdly, input int cdly, input logic [63:0] model,
                              input logic exp_err, input logic [63:0] exp_rdata);
    vec_t v;
    v.idx = idx; v.we = we; v.addr = addr; v.width = width; v.wdata = wdata;
    v.rdly = rdly; v.cdly = cdly; v.model = model;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic set_fields(input vec_t v);
    req_we[v.idx]                      = v.we;
    req_addr[int'(v.idx)*28 +: 28]     = v.addr;
    req_width[int'(v.idx)*2 +: 2]      = v.width;
    req_wdata[int'(v.idx)*64 +: 64]    = v.wdata;
  endtask

  // Called at a negedge while the arbiter is IDLE with req already driven.
  task automatic do_txn(input vec_t v, input bit keep);
    int cyc;
    int k;
    int exp_k;
    bit stall_bad;
    cyc = 0;
    stall_bad = 0;
    mem_bus.mem_ready = (v.rdly == 0);
    while (cyc < 300) begin
      @(negedge clk_cpu);
      cyc++;
      if (mem_bus.mem_wstrobe || mem_bus.mem_rstrobe) break;
      if (!busy) stall_bad = 1;
      if (cyc == 1 + v.rdly) mem_bus.mem_ready = 1'b1;
      mem_bus.mem_transaction_complete = (v.rdly > 10 && cyc == 10);
    end
    mem_bus.mem_transaction_complete = 1'b0;
    mem_bus.mem_ready = 1'b0;
    chk("strobe_latency", 64'(cyc), 64'(2 + v.rdly));
    if (v.rdly > 0) chk("issue_stall_busy", 64'(stall_bad), 64'd0);
    chk("wstrobe", 64'(mem_bus.mem_wstrobe), 64'(v.we));
    chk("rstrobe", 64'(mem_bus.mem_rstrobe), 64'(!v.we));
    chk("mem_addr", 64'(mem_bus.mem_addr), 64'(v.addr));
    chk("mem_width", 64'(mem_bus.mem_width), 64'(v.width));
    chk("mem_d_to_ram", mem_bus.mem_d_to_ram, v.wdata);
    chk("owner", 64'(owner), 64'(v.idx));

    k = 0;
    mem_bus.mem_d_from_ram = v.model;
    while (k < 300) begin
      mem_bus.mem_transaction_complete = (v.cdly >= 0 && k == v.cdly);
      @(negedge clk_cpu);
      k++;
      if (k == 1) chk("strobe_single", 64'({mem_bus.mem_wstrobe, mem_bus.mem_rstrobe}), 64'd0);
      if (done != 2'b00) break;
    end
    mem_bus.mem_transaction_complete = 1'b0;
    exp_k = (v.cdly >= 0) ? v.cdly + 1 : TMO;
    chk("done_latency", 64'(k), 64'(exp_k));
    chk("done", 64'(done), 64'(2'b01 << v.idx));
    chk("err", 64'(err), v.exp_err ? 64'(2'b01 << v.idx) : 64'd0);
    chk("rdata", rdata, v.exp_rdata);
    @(negedge clk_cpu);
    chk("done_clear", 64'(done), 64'd0);
    chk("err_clear", 64'(err), 64'd0);
    chk("back_idle", 64'(busy), 64'd0);
    if (!keep) req = 2'b00;
  endtask

  vec_t tbl[6];
  vec_t rr_a1, rr_a2, rr_a3, rr_b;

  initial begin
    int cyc;

    tbl[0] = mk(1'b0, 1'b1, 28'h0101010, WIDTH_32, 64'h0000000000012345, 0, 3, 64'hBAD, 1'b0, 64'h0);
    tbl[1] = mk(1'b0, 1'b0, 28'h0101010, WIDTH_32, 64'h0, 0, 1, 64'h0000000000012345, 1'b0, 64'h12345);
    tbl[2] = mk(1'b1, 1'b1, 28'hFFFFFFF, WIDTH_64, 64'hDEADBEEFCAFEF00D, 0, 0, 64'hBAD, 1'b0, 64'h12345);
    tbl[3] = mk(1'b1, 1'b0, 28'h0000000, WIDTH_8, 64'h0, 0, 5, 64'hA5A5A5A5A5A5A5A5, 1'b0, 64'hA5A5A5A5A5A5A5A5);
    tbl[4] = mk(1'b0, 1'b0, 28'h1234567, WIDTH_16, 64'h0, 0, -1, 64'h77, 1'b1, 64'hA5A5A5A5A5A5A5A5);
    tbl[5] = mk(1'b1, 1'b1, 28'h8000001, WIDTH_32, 64'h0123456789ABCDEF, 50, 2, 64'hBAD, 1'b0, 64'hA5A5A5A5A5A5A5A5);

    rr_a1 = mk(1'b0, 1'b1, 28'h0000100, WIDTH_64, 64'h1111, 0, 0, 64'hBAD, 1'b0, 64'hA5A5A5A5A5A5A5A5);
    rr_b  = mk(1'b1, 1'b0, 28'h0000200, WIDTH_64, 64'h0, 0, 1, 64'h2222, 1'b0, 64'h2222);
    rr_a2 = mk(1'b0, 1'b1, 28'h0000100, WIDTH_64, 64'h1111, 0, 0, 64'hBAD, 1'b0, 64'h2222);
    rr_a3 = mk(1'b0, 1'b1, 28'h0000100, WIDTH_64, 64'h1111, 0, 0, 64'hBAD, 1'b0, 64'h0);

    rst_n = 1'b0;
    req = '0; req_we = '0; req_addr = '0; req_width = '0; req_wdata = '0;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_transaction_complete = 1'b0;
    mem_bus.mem_d_from_ram = '0;

    // Reset state.
    repeat (2) @(negedge clk_cpu);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_strobes", 64'({mem_bus.mem_wstrobe, mem_bus.mem_rstrobe}), 64'd0);
    chk("rst_addr", 64'(mem_bus.mem_addr), 64'd0);
    chk("rst_d_to_ram", mem_bus.mem_d_to_ram, 64'd0);
    chk("rst_width", 64'(mem_bus.mem_width), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    // Single-requester vectors.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_cpu);
      set_fields(tbl[i]);
      req[tbl[i].idx] = 1'b1;
      do_txn(tbl[i], 1'b0);
    end

    // Both requests held: grants must alternate starting with requester 0.
    @(negedge clk_cpu);
    set_fields(rr_a1);
    set_fields(rr_b);
    req = 2'b11;
    do_txn(rr_a1, 1'b1);
    do_txn(rr_b,  1'b1);
    do_txn(rr_a2, 1'b1);
    do_txn(rr_b,  1'b0);

    // Reset while the strobe is in flight, then a stray complete.
    @(negedge clk_cpu);
    set_fields(mk(1'b0, 1'b0, 28'h0ABCDEF, WIDTH_32, 64'h0, 0, 0, 64'h0, 1'b0, 64'h0));
    req = 2'b01;
    mem_bus.mem_ready = 1'b1;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk_cpu);
      cyc++;
      if (mem_bus.mem_rstrobe || mem_bus.mem_wstrobe) break;
    end
    chk("rstseq_strobe_seen", 64'(mem_bus.mem_rstrobe), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstseq_strobe_drop", 64'({mem_bus.mem_wstrobe, mem_bus.mem_rstrobe}), 64'd0);
    chk("rstseq_done", 64'(done), 64'd0);
    chk("rstseq_busy", 64'(busy), 64'd0);
    chk("rstseq_rdata", rdata, 64'd0);
    chk("rstseq_addr", 64'(mem_bus.mem_addr), 64'd0);
    req = 2'b00;
    mem_bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk_cpu);
    rst_n = 1'b1;
    @(negedge clk_cpu);
    mem_bus.mem_d_from_ram = 64'hFEEDFACE;
    mem_bus.mem_transaction_complete = 1'b1;
    @(negedge clk_cpu);
    mem_bus.mem_transaction_complete = 1'b0;
    chk("stray_cmpl_done", 64'(done), 64'd0);
    chk("stray_cmpl_busy", 64'(busy), 64'd0);
    @(negedge clk_cpu);
    chk("stray_cmpl_done2", 64'(done), 64'd0);
    chk("stray_cmpl_rdata", rdata, 64'd0);

    // After reset requester 0 wins the first tie again.
    set_fields(rr_a3);
    set_fields(rr_b);
    req = 2'b11;
    do_txn(rr_a3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
